// File: rtl/demapper_q.sv
// ----------------------------------------------------------------------------
// demapper_q
// Q-channel correlating demapper. Each bit spans SPB samples. Every accepted
// sample is multiplied by a programmable reference waveform and accumulated.
// At the end of a symbol, the sign of the correlation gives the bit. The
// tie-break (sum = 0) gives a 1. Sixteen bits make a word, with bit 0 sent
// first. A word is registered once and then offered on a valid/ready output.
// If the output is still occupied when a new word arrives, the new word is
// dropped and a sticky overflow flag is set.
//
// Parameters
//   SPB    samples per bit (power of two, 2..16)
//   ACC_W  accumulator width (must be >= 32 + log2(SPB))
// Ports
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   rx_en           demapping enable; low clears symbol/bit alignment
//   sample_in       signed Q sample, qualified by sample_valid
//   coef_we/addr/   reference-table write port (new value seen next cycle)
//     coef_data
//   frame_data      demapped word, bit 0 = first received bit
//   frame_valid     frame_data holds an unconsumed word
//   frame_ready     consumer accepts frame_data
//   overflow        sticky: a completed word was dropped
//   bit_cnt         bits collected toward the current word
// ----------------------------------------------------------------------------
module demapper_q #(
    parameter int unsigned SPB   = 4,
    parameter int unsigned ACC_W = 34
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx_en,
    input  logic signed [15:0]        sample_in,
    input  logic                      sample_valid,
    input  logic                      coef_we,
    input  logic [$clog2(SPB)-1:0]    coef_addr,
    input  logic signed [15:0]        coef_data,
    output logic [15:0]               frame_data,
    output logic                      frame_valid,
    input  logic                      frame_ready,
    output logic                      overflow,
    output logic [3:0]                bit_cnt
);

    localparam int unsigned SAMP_W    = $clog2(SPB);
    localparam int unsigned COEF_STEP = 16 / SPB;

    // 16-point cosine period, scaled by 32767 and rounded. Shorter periods
    // decimate it.
    function automatic logic signed [15:0] cos16(input logic [3:0] j);
        case (j)
            4'd0:    cos16 =  16'sd32767;
            4'd1:    cos16 =  16'sd30273;
            4'd2:    cos16 =  16'sd23170;
            4'd3:    cos16 =  16'sd12539;
            4'd4:    cos16 =  16'sd0;
            4'd5:    cos16 = -16'sd12539;
            4'd6:    cos16 = -16'sd23170;
            4'd7:    cos16 = -16'sd30273;
            4'd8:    cos16 = -16'sd32767;
            4'd9:    cos16 = -16'sd30273;
            4'd10:   cos16 = -16'sd23170;
            4'd11:   cos16 = -16'sd12539;
            4'd12:   cos16 =  16'sd0;
            4'd13:   cos16 =  16'sd12539;
            4'd14:   cos16 =  16'sd23170;
            default: cos16 =  16'sd30273;
        endcase
    endfunction

    logic signed [15:0]      r_coef [SPB];
    logic [SAMP_W-1:0]       r_samp_cnt;
    logic signed [ACC_W-1:0] r_acc;
    logic [15:0]             r_shift;
    logic [3:0]              r_bit_cnt;
    logic                    r_pend_valid;
    logic [15:0]             r_pend_word;
    logic [15:0]             r_frame_data;
    logic                    r_frame_valid;
    logic                    r_overflow;

    logic                    w_last;
    logic signed [31:0]      w_prod;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_bit;
    logic                    w_word_done;
    logic [15:0]             w_word;

    // Correlation datapath. The table read sees the pre-write value.
    assign w_last      = (r_samp_cnt == SAMP_W'(SPB - 1));
    assign w_prod      = sample_in * r_coef[r_samp_cnt];
    assign w_sum       = r_acc + ACC_W'(w_prod);
    assign w_bit       = ~w_sum[ACC_W-1];
    assign w_word_done = rx_en & sample_valid & w_last & (r_bit_cnt == 4'd15);
    assign w_word      = {w_bit, r_shift[14:0]};

    // Reference-waveform table.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SPB; k++) begin
                r_coef[k] <= cos16(4'(k * COEF_STEP));
            end
        end else if (coef_we) begin
            r_coef[coef_addr] <= coef_data;
        end
    end

    // Symbol and bit alignment, accumulator and bit collection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_samp_cnt <= '0;
            r_acc      <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
        end else if (!rx_en) begin
            r_samp_cnt <= '0;
            r_acc      <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
        end else if (sample_valid) begin
            if (w_last) begin
                r_acc              <= '0;
                r_samp_cnt         <= '0;
                r_shift[r_bit_cnt] <= w_bit;
                r_bit_cnt          <= r_bit_cnt + 4'd1;
            end else begin
                r_acc      <= w_sum;
                r_samp_cnt <= r_samp_cnt + SAMP_W'(1);
            end
        end
    end

    // One-stage hold for a completed word. The word reaches the output one
    // edge after its last sample is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend_word  <= '0;
        end else begin
            r_pend_valid <= w_word_done;
            if (w_word_done) begin
                r_pend_word <= w_word;
            end
        end
    end

    // Output register with a valid/ready handshake and a sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_data  <= '0;
            r_frame_valid <= 1'b0;
            r_overflow    <= 1'b0;
        end else if (r_pend_valid) begin
            if (!r_frame_valid || frame_ready) begin
                r_frame_data  <= r_pend_word;
                r_frame_valid <= 1'b1;
            end else begin
                r_overflow <= 1'b1;
            end
        end else if (r_frame_valid && frame_ready) begin
            r_frame_valid <= 1'b0;
        end
    end

    assign frame_data  = r_frame_data;
    assign frame_valid = r_frame_valid;
    assign overflow    = r_overflow;
    assign bit_cnt     = r_bit_cnt;

endmodule

// File: tb/tb_demapper_q.sv
// ----------------------------------------------------------------------------
// tb_demapper_q
// Self-checking bench for demapper_q with SPB=4. A behavioural model predicts
// the outputs from accepted samples, correlation sums, bit lists and the
// output handshake. One process compares the DUT with the model on every
// falling edge. Directed scenarios also pin literal expected words.
// ----------------------------------------------------------------------------
module tb_demapper_q;

    localparam int unsigned SPB   = 4;
    localparam int unsigned ACC_W = 34;

    logic               clk;
    logic               reset;
    logic               rx_en;
    logic signed [15:0] sample_in;
    logic               sample_valid;
    logic               coef_we;
    logic [1:0]         coef_addr;
    logic signed [15:0] coef_data;
    logic [15:0]        frame_data;
    logic               frame_valid;
    logic               frame_ready;
    logic               overflow;
    logic [3:0]         bit_cnt;

    demapper_q #(.SPB(SPB), .ACC_W(ACC_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_en        (rx_en),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .coef_we      (coef_we),
        .coef_addr    (coef_addr),
        .coef_data    (coef_data),
        .frame_data   (frame_data),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .overflow     (overflow),
        .bit_cnt      (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_coef [SPB];
    int          m_samp;
    longint      m_acc;
    int          m_nbits;
    logic [15:0] m_word;
    logic        m_pend;
    logic [15:0] m_pend_word;
    logic [15:0] m_fd;
    logic        m_fv;
    logic        m_ovf;

    function automatic int cos_ref(input int k);
        real x;
        x = 32767.0 * $cos(2.0 * 3.14159265358979 * k / SPB);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < SPB; k++) m_coef[k] = cos_ref(k);
        m_samp = 0; m_acc = 0; m_nbits = 0; m_word = '0;
        m_pend = 1'b0; m_pend_word = '0;
        m_fd = '0; m_fv = 1'b0; m_ovf = 1'b0;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_reset();
        end else begin
            // output side sees the word completed on the previous edge
            if (m_pend) begin
                if (!m_fv || frame_ready) begin
                    m_fd = m_pend_word;
                    m_fv = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m_fv && frame_ready) begin
                m_fv = 1'b0;
            end
            m_pend = 1'b0;
            if (!rx_en) begin
                m_samp = 0; m_acc = 0; m_nbits = 0; m_word = '0;
            end else if (sample_valid) begin
                m_acc += longint'(sample_in) * longint'(m_coef[m_samp]);
                if (m_samp == SPB - 1) begin
                    m_word[m_nbits] = (m_acc >= 0);
                    m_nbits++;
                    m_acc  = 0;
                    m_samp = 0;
                    if (m_nbits == 16) begin
                        m_pend      = 1'b1;
                        m_pend_word = m_word;
                        m_nbits     = 0;
                        m_word      = '0;
                    end
                end else begin
                    m_samp++;
                end
            end
            if (coef_we) m_coef[coef_addr] = int'(coef_data);
        end
    end

    // ---------------- cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("frame_data",  frame_data,          m_fd);
            check("frame_valid", 16'(frame_valid),    16'(m_fv));
            check("overflow",    16'(overflow),       16'(m_ovf));
            check("bit_cnt",     16'(bit_cnt),        16'(m_nbits));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] fd, input logic fv,
                              input logic ovf, input logic [3:0] bc);
        check({tag, "_data"},  frame_data,        fd);
        check({tag, "_valid"}, 16'(frame_valid),  16'(fv));
        check({tag, "_ovf"},   16'(overflow),     16'(ovf));
        check({tag, "_bcnt"},  16'(bit_cnt),      16'(bc));
    endtask

    // One symbol per bit against the default cosine table. A '1' is
    // {+a,0,-a,0} and a '0' is {-a,0,+a,0}.
    task automatic send_samples(input logic [15:0] w, input int amp, input int n);
        int s;
        for (int i = 0; i < n; i++) begin
            s = (i % 4 == 0) ? (w[i / 4] ? amp : -amp) :
                (i % 4 == 2) ? (w[i / 4] ? -amp : amp) : 0;
            sample_in    = 16'(s);
            sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
    endtask

    task automatic consume();
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rx_en = 1'b0; sample_in = '0; sample_valid = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0; frame_ready = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        expect_out("idle", 16'h0000, 1'b0, 1'b0, 4'd0);

        // alternating word through the default table; one edge of latency
        rx_en = 1'b1;
        send_samples(16'h5555, 1000, 64);
        expect_out("lat0", 16'h0000, 1'b0, 1'b0, 4'd0);
        tick();
        expect_out("w5555", 16'h5555, 1'b1, 1'b0, 4'd0);
        consume();
        expect_out("cons1", 16'h5555, 1'b0, 1'b0, 4'd0);

        // all-zero samples: every tie resolves to 1
        send_samples(16'h0000, 0, 64);
        tick();
        expect_out("ties", 16'hFFFF, 1'b1, 1'b0, 4'd0);
        consume();

        // second word dropped while the first is held
        send_samples(16'h5555, 1500, 64);
        send_samples(16'h0000, 700, 64);
        tick();
        expect_out("ovf", 16'h5555, 1'b1, 1'b1, 4'd0);
        consume();
        expect_out("ovf_cons", 16'h5555, 1'b0, 1'b1, 4'd0);

        // new word loads on the same edge that accepts the old one
        reset = 1'b1; tick(); reset = 1'b0; tick();
        send_samples(16'hA5C3, 900, 64);
        send_samples(16'h3C5A, 1200, 64);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        expect_out("same_edge", 16'h3C5A, 1'b1, 1'b0, 4'd0);
        consume();

        // rx_en drop discards a partial symbol and partial bits
        for (int i = 0; i < 10; i++) begin
            sample_in = 16'($urandom); sample_valid = 1'b1; tick();
        end
        sample_valid = 1'b0; rx_en = 1'b0; tick(); rx_en = 1'b1;
        send_samples(16'h00FF, 800, 64);
        tick();
        expect_out("realign", 16'h00FF, 1'b1, 1'b0, 4'd0);

        // async reset pulse mid-word discards the partial word
        send_samples(16'hFFFF, 600, 30);
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        tick();
        expect_out("rst_mid", 16'h0000, 1'b0, 1'b0, 4'd0);
        send_samples(16'hFFFF, 600, 34);
        repeat (2) tick();
        expect_out("post_rst", 16'h0000, 1'b0, 1'b0, 4'd8);

        // randomized traffic against the model
        for (int c = 0; c < 5000; c++) begin
            rx_en        = ($urandom_range(0, 299) != 0);
            sample_valid = ($urandom_range(0, 3) != 0);
            sample_in    = 16'($urandom);
            coef_we      = ($urandom_range(0, 40) == 0);
            coef_addr    = 2'($urandom);
            coef_data    = 16'($urandom);
            frame_ready  = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 2499) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
            tick();
        end
        rx_en = 1'b0; sample_valid = 1'b0; coef_we = 1'b0; frame_ready = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/demapper_q.md
DEMAPPER_Q -- requirements
Module: demapper_q

Interface
REQ-001 Parameter SPB, default 4: samples per bit; power of two, 2..16.
REQ-002 Parameter ACC_W, default 34: correlator accumulator width; SHALL be >= 32+log2(SPB).
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 rx_en  in  1  demapping enable; low clears symbol/bit alignment.
REQ-006 sample_in  in  16  signed Q-channel sample.
REQ-007 sample_valid  in  1  sample_in valid this cycle.
REQ-008 coef_we  in  1  reference-waveform table write strobe.
REQ-009 coef_addr  in  log2(SPB)  table write address.
REQ-010 coef_data  in  16  signed table write data.
REQ-011 frame_data  out  16  demapped word, bit 0 = first received bit.
REQ-012 frame_valid  out  1  frame_data holds an unconsumed word.
REQ-013 frame_ready  in  1  consumer accepts frame_data when frame_valid=1.
REQ-014 overflow  out  1  sticky: a completed word was dropped.
REQ-015 bit_cnt  out  4  bits collected toward the current word, 0..15.

Function
REQ-016 A sample is accepted when rx_en=1 and sample_valid=1; all other cycles leave samp_cnt, accumulator, shift register and bit_cnt unchanged, except as REQ-023 requires.
REQ-017 On each accepted sample, the block SHALL form sum = acc + sample_in*coef[samp_cnt]; product is a full signed 32-bit value, sum is signed ACC_W-bit with no saturation.
REQ-018 If samp_cnt < SPB-1: acc <= sum, samp_cnt <= samp_cnt+1.
REQ-019 If samp_cnt = SPB-1: decision bit = 1 when sum >= 0, else 0 (tie resolves to 1); acc <= 0; samp_cnt <= 0; bit written to shift position bit_cnt.
REQ-020 After a decision, bit_cnt increments; a decision at bit_cnt=15 wraps bit_cnt to 0 and completes a word.
REQ-021 Latency: a completed word SHALL appear on frame_data with frame_valid=1 on the clock edge after the edge that accepted the word's final sample.
REQ-022 Output handshake: frame_valid stays 1 and frame_data stays stable until frame_valid and frame_ready are both 1; frame_valid then clears unless a new word is loaded on the same edge.
REQ-023 rx_en=0 SHALL clear samp_cnt, acc, shift register and bit_cnt on the next edge; the output register, frame_valid and overflow are unaffected.
REQ-024 Word completion with frame_valid=0, or with frame_valid=1 and frame_ready=1 on the same edge: new word loaded, frame_valid=1, no overflow.
REQ-025 Word completion with frame_valid=1 and frame_ready=0: new word discarded, frame_data unchanged, overflow <= 1.
REQ-026 overflow is cleared only by reset.
REQ-027 Coefficient write on coef_we=1 takes effect on the next edge; a same-cycle read of the address being written uses the old value.
REQ-028 Coefficient writes are permitted at any time, including while rx_en=1.

Reset
REQ-029 While reset=1: frame_data=0, frame_valid=0, overflow=0, bit_cnt=0, samp_cnt=0, acc=0, shift register=0.
REQ-030 Reset loads the coefficient table with one cosine period, entry k = round(32767*cos(2*pi*k/SPB)); for SPB=4 this is 0x7FFF, 0x0000, 0x8001, 0x0000.
REQ-031 Reset asserted mid-word SHALL discard the partial word; no frame_valid results from it.

Verification
REQ-032 Reset, then idle -> all outputs 0; read-back via demapping confirms default table.
REQ-033 rx_en=1; 16 symbols alternating {1000,0,-1000,0} then {-1000,0,1000,0}, first symbol positive -> frame_data=0x5555 and frame_valid=1 one cycle after the 64th sample; bit_cnt=0.
REQ-034 64 zero samples -> ties resolve to 1 -> frame_data=0xFFFF.
REQ-035 frame_ready=0; send two full words 0x5555 then 0x0000 -> frame_data stays 0x5555, overflow=1; frame_ready=1 -> frame_valid=0, overflow stays 1.
REQ-036 Second word completes on the same edge that frame_ready=1 accepts the first -> frame_data=new word, frame_valid=1, overflow=0.
REQ-037 rx_en dropped after 10 samples, then 64 clean samples encoding 0x00FF -> frame_data=0x00FF, no stale bits; repeat with async reset pulse mid-word -> no frame_valid, outputs 0.
